// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared configuration for the common-data-bus arbiter slice:
//               ROB tag width, default per-source buffer depth and the
//               encoding of the broadcast source field.
// Revision    : 1.0  initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int   CDB_ROB_LOG   = 4;
    localparam int   CDB_BUF_DEPTH = 4;

    localparam logic CDB_SRC_ALU   = 1'b0;
    localparam logic CDB_SRC_LSB   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cdb_fifo
// Description : Small circular result buffer for one CDB source. A pop in
//               the same cycle frees a slot, so a full buffer that is also
//               being drained still accepts a push.
// Revision    : 1.0  initial release
// ============================================================================
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int WIDTH = CDB_ROB_LOG + 32,
    parameter int DEPTH = CDB_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     next_full,
    output logic                     overflow
);

    localparam int           PW     = $clog2(DEPTH);
    localparam logic [PW:0]  C_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]  C_NEAR = (PW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW:0]      count_q, count_d;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign head_data = mem_q[head_q];
    assign count     = count_q;
    assign next_full = (count_q >= C_NEAR);

    // Next pointer/count/storage state; pop is evaluated first so it can free a slot for the push.
    always_comb begin
        w_full   = (count_q == C_FULL);
        w_pop    = pop && (count_q != '0);
        w_push   = push && (!w_full || w_pop);
        overflow = push && w_full && !w_pop;
        mem_d    = mem_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_pop) begin
                head_d = head_q + PW'(1);
            end
            if (w_push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PW'(1);
            end
            count_d = count_q + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // Pointer and count registers; the data array carries no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Merges the ALU and LSB result streams onto one registered
//               common data bus using per-source buffers and round-robin
//               arbitration. Flushed on mispredict, frozen when rdy is low.
// Revision    : 1.0  initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_LOG   = CDB_ROB_LOG,
    parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               jump_flag,
    input  logic               alu_valid,
    input  logic [ROB_LOG-1:0] alu_rob,
    input  logic [31:0]        alu_value,
    input  logic               lsb_valid,
    input  logic [ROB_LOG-1:0] lsb_rob,
    input  logic [31:0]        lsb_value,
    output logic               alu_next_full,
    output logic               lsb_next_full,
    output logic               cdb_valid,
    output logic [ROB_LOG-1:0] cdb_rob,
    output logic [31:0]        cdb_value,
    output logic               cdb_src,
    output logic               overflow_err
);

    localparam int W  = ROB_LOG + 32;
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic               w_active;
    logic               w_alu_push, w_lsb_push;
    logic               w_alu_pop, w_lsb_pop;
    logic [W-1:0]       w_alu_head, w_lsb_head;
    logic [CW-1:0]      w_alu_count, w_lsb_count;
    logic               w_alu_ovf, w_lsb_ovf;
    logic               w_alu_ne, w_lsb_ne;

    logic               cdb_valid_q, cdb_valid_d;
    logic [ROB_LOG-1:0] cdb_rob_q, cdb_rob_d;
    logic [31:0]        cdb_value_q, cdb_value_d;
    logic               cdb_src_q, cdb_src_d;
    logic               last_grant_q, last_grant_d;
    logic               overflow_err_q, overflow_err_d;

    // Pushes and pops only happen when running and not flushing.
    assign w_active   = rdy && !jump_flag;
    assign w_alu_push = w_active && alu_valid;
    assign w_lsb_push = w_active && lsb_valid;
    assign w_alu_ne   = (w_alu_count != '0);
    assign w_lsb_ne   = (w_lsb_count != '0);

    cdb_fifo #(.WIDTH(W), .DEPTH(BUF_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_flag),
        .push      (w_alu_push),
        .push_data ({alu_rob, alu_value}),
        .pop       (w_alu_pop),
        .head_data (w_alu_head),
        .count     (w_alu_count),
        .next_full (alu_next_full),
        .overflow  (w_alu_ovf)
    );

    cdb_fifo #(.WIDTH(W), .DEPTH(BUF_DEPTH)) u_lsb_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_flag),
        .push      (w_lsb_push),
        .push_data ({lsb_rob, lsb_value}),
        .pop       (w_lsb_pop),
        .head_data (w_lsb_head),
        .count     (w_lsb_count),
        .next_full (lsb_next_full),
        .overflow  (w_lsb_ovf)
    );

    // Round-robin grant on registered buffer state, and the next broadcast register contents.
    always_comb begin
        w_alu_pop      = 1'b0;
        w_lsb_pop      = 1'b0;
        cdb_valid_d    = 1'b0;
        cdb_rob_d      = cdb_rob_q;
        cdb_value_d    = cdb_value_q;
        cdb_src_d      = cdb_src_q;
        last_grant_d   = last_grant_q;
        overflow_err_d = overflow_err_q || w_alu_ovf || w_lsb_ovf;
        if (jump_flag) begin
            cdb_rob_d    = '0;
            cdb_value_d  = '0;
            cdb_src_d    = CDB_SRC_ALU;
            last_grant_d = CDB_SRC_LSB;
        end else if (rdy) begin
            if (w_alu_ne && (!w_lsb_ne || last_grant_q == CDB_SRC_LSB)) begin
                w_alu_pop    = 1'b1;
                cdb_valid_d  = 1'b1;
                {cdb_rob_d, cdb_value_d} = w_alu_head;
                cdb_src_d    = CDB_SRC_ALU;
                last_grant_d = CDB_SRC_ALU;
            end else if (w_lsb_ne) begin
                w_lsb_pop    = 1'b1;
                cdb_valid_d  = 1'b1;
                {cdb_rob_d, cdb_value_d} = w_lsb_head;
                cdb_src_d    = CDB_SRC_LSB;
                last_grant_d = CDB_SRC_LSB;
            end
        end
    end

    // Broadcast register, round-robin pointer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q    <= 1'b0;
            cdb_rob_q      <= '0;
            cdb_value_q    <= '0;
            cdb_src_q      <= CDB_SRC_ALU;
            last_grant_q   <= CDB_SRC_LSB;
            overflow_err_q <= 1'b0;
        end else begin
            cdb_valid_q    <= cdb_valid_d;
            cdb_rob_q      <= cdb_rob_d;
            cdb_value_q    <= cdb_value_d;
            cdb_src_q      <= cdb_src_d;
            last_grant_q   <= last_grant_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_rob      = cdb_rob_q;
    assign cdb_value    = cdb_value_q;
    assign cdb_src      = cdb_src_q;
    assign overflow_err = overflow_err_q;

endmodule
`default_nettype wire
